conv_layer_stream: RTL and testbench

Streaming multi-filter 3x3 convolution layer: accepts a raster-order pixel stream, builds 3x3 windows internally, and computes NUM_FILTERS valid-mode convolutions in parallel, one window per accepted pixel. Per-filter weights and bias are runtime-loadable. Output passes through optional ReLU behind a ready/valid handshake with backpressure. It replaces the fixed single-filter line-buffer/conv/ReLU chain and feeds the pooling/next-layer stage of the CNN pipeline.

---
 rtl/conv_pkg.sv | 25 ++
 rtl/window_gen.sv | 104 ++++++++++
 rtl/conv_layer_stream.sv | 192 +++++++++++++++++++
 tb/tb_conv_layer_stream.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// Shared constants for the streaming 3x3 convolution layer: coefficient
// addressing, window tap indices and product width helper.
package conv_pkg;

   localparam int COEF_PER_FILTER = 10;
   localparam int BIAS_OFFSET     = 9;
   localparam int NUM_TAPS        = 9;

   // Row-major tap indices of the 3x3 window (row 0 is the oldest line).
   localparam int TAP_TL = 0;
   localparam int TAP_TC = 1;
   localparam int TAP_TR = 2;
   localparam int TAP_ML = 3;
   localparam int TAP_MC = 4;
   localparam int TAP_MR = 5;
   localparam int TAP_BL = 6;
   localparam int TAP_BC = 7;
   localparam int TAP_BR = 8;

   // Unsigned pixel gets one sign bit, then times a signed weight.
   function automatic int prod_width(input int data_w, input int weight_w);
      return data_w + 1 + weight_w;
   endfunction

endpackage

// File: rtl/window_gen.sv
// Raster-order pixel counters, two line buffers and the 3x3 shift window.
// Everything loads only when en (the global pipeline advance) is high.
module window_gen
   import conv_pkg::*;
#(
   parameter int IMG_WIDTH  = 28,
   parameter int IMG_HEIGHT = 28,
   parameter int DATA_WIDTH = 8
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           en,
   input  logic [DATA_WIDTH-1:0]          pixel_in,
   input  logic                           pixel_valid,
   output logic [NUM_TAPS*DATA_WIDTH-1:0] win,
   output logic                           win_valid,
   output logic [$clog2(IMG_HEIGHT)-1:0]  win_row,
   output logic [$clog2(IMG_WIDTH)-1:0]   win_col
);

   localparam int CW = $clog2(IMG_WIDTH);
   localparam int RW = $clog2(IMG_HEIGHT);
   localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
   localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);

   logic [CW-1:0]         col_r;
   logic [RW-1:0]         row_r;
   logic [DATA_WIDTH-1:0] lb_a_r [IMG_WIDTH];
   logic [DATA_WIDTH-1:0] lb_b_r [IMG_WIDTH];
   logic [DATA_WIDTH-1:0] win_r  [NUM_TAPS];
   logic                  win_valid_r;
   logic [RW-1:0]         win_row_r;
   logic [CW-1:0]         win_col_r;
   logic                  accept_s;
   logic [DATA_WIDTH-1:0] up2_s;
   logic [DATA_WIDTH-1:0] up1_s;

   assign accept_s = en & pixel_valid;
   assign up2_s    = lb_b_r[col_r];
   assign up1_s    = lb_a_r[col_r];

   // Raster counters: column wraps into row, row wraps into the next frame.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         col_r <= '0;
         row_r <= '0;
      end else if (accept_s) begin
         if (col_r == COL_LAST) begin
            col_r <= '0;
            row_r <= (row_r == ROW_LAST) ? RW'(0) : row_r + RW'(1);
         end else begin
            col_r <= col_r + CW'(1);
         end
      end
   end

   // Line buffers: lb_a holds the previous row, lb_b the one before; no reset needed.
   always_ff @(posedge clk) begin
      if (accept_s) begin
         lb_b_r[col_r] <= lb_a_r[col_r];
         lb_a_r[col_r] <= pixel_in;
      end
   end

   // Shift window left by one column and tag it valid once three full columns of three rows exist.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NUM_TAPS; i++) begin
            win_r[i] <= '0;
         end
         win_valid_r <= 1'b0;
         win_row_r   <= '0;
         win_col_r   <= '0;
      end else if (en) begin
         win_valid_r <= pixel_valid && (row_r >= RW'(2)) && (col_r >= CW'(2));
         if (pixel_valid) begin
            win_r[TAP_TL] <= win_r[TAP_TC];
            win_r[TAP_TC] <= win_r[TAP_TR];
            win_r[TAP_TR] <= up2_s;
            win_r[TAP_ML] <= win_r[TAP_MC];
            win_r[TAP_MC] <= win_r[TAP_MR];
            win_r[TAP_MR] <= up1_s;
            win_r[TAP_BL] <= win_r[TAP_BC];
            win_r[TAP_BC] <= win_r[TAP_BR];
            win_r[TAP_BR] <= pixel_in;
            win_row_r     <= row_r - RW'(2);
            win_col_r     <= col_r - CW'(2);
         end
      end
   end

   // Flatten the window taps for the multiply stage.
   always_comb begin
      win = '0;
      for (int k = 0; k < NUM_TAPS; k++) begin
         win[k*DATA_WIDTH +: DATA_WIDTH] = win_r[k];
      end
   end

   assign win_valid = win_valid_r;
   assign win_row   = win_row_r;
   assign win_col   = win_col_r;

endmodule

// File: rtl/conv_layer_stream.sv
// Streaming multi-filter 3x3 valid-mode convolution with loadable weights/bias.
// Optional ReLU on the output when CONV_RELU_EN is defined.
module conv_layer_stream
   import conv_pkg::*;
#(
   parameter int IMG_WIDTH    = 28,
   parameter int IMG_HEIGHT   = 28,
   parameter int DATA_WIDTH   = 8,
   parameter int WEIGHT_WIDTH = 8,
   parameter int ACC_WIDTH    = 20,
   parameter int NUM_FILTERS  = 4,
   parameter int WADDR_WIDTH  = $clog2(NUM_FILTERS*COEF_PER_FILTER)
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic [DATA_WIDTH-1:0]            pixel_in,
   input  logic                             pixel_valid,
   output logic                             pixel_ready,
   input  logic                             wt_we,
   input  logic [WADDR_WIDTH-1:0]           wt_addr,
   input  logic [WEIGHT_WIDTH-1:0]          wt_data,
   output logic [NUM_FILTERS*ACC_WIDTH-1:0] out_data,
   output logic                             out_valid,
   input  logic                             out_ready,
   output logic [$clog2(IMG_HEIGHT)-1:0]    out_row,
   output logic [$clog2(IMG_WIDTH)-1:0]     out_col,
   output logic                             out_last
);

   localparam int CW       = $clog2(IMG_WIDTH);
   localparam int RW       = $clog2(IMG_HEIGHT);
   localparam int PW       = prod_width(DATA_WIDTH, WEIGHT_WIDTH);
   localparam int NUM_COEF = NUM_FILTERS * COEF_PER_FILTER;
   localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 3);
   localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 3);

   logic                             advance_s;
   logic [NUM_TAPS*DATA_WIDTH-1:0]   win_s;
   logic                             win_valid_s;
   logic [RW-1:0]                    win_row_s;
   logic [CW-1:0]                    win_col_s;

   logic signed [WEIGHT_WIDTH-1:0]   coef_r [NUM_COEF];

   logic [NUM_TAPS*DATA_WIDTH-1:0]   s1_win_r;
   logic                             s1_valid_r;
   logic [RW-1:0]                    s1_row_r;
   logic [CW-1:0]                    s1_col_r;

   logic signed [PW-1:0]             prod_s [NUM_FILTERS][NUM_TAPS];
   logic signed [PW-1:0]             prod_r [NUM_FILTERS][NUM_TAPS];
   logic signed [WEIGHT_WIDTH-1:0]   bias_r [NUM_FILTERS];
   logic                             s2_valid_r;
   logic [RW-1:0]                    s2_row_r;
   logic [CW-1:0]                    s2_col_r;

   logic [NUM_FILTERS*ACC_WIDTH-1:0] res_s;
   logic [NUM_FILTERS*ACC_WIDTH-1:0] out_data_r;
   logic                             out_valid_r;
   logic [RW-1:0]                    out_row_r;
   logic [CW-1:0]                    out_col_r;
   logic                             out_last_r;

   // One global stall: nothing moves while a result waits on downstream.
   assign advance_s   = ~out_valid_r | out_ready;
   assign pixel_ready = advance_s;

   window_gen #(
      .IMG_WIDTH  (IMG_WIDTH),
      .IMG_HEIGHT (IMG_HEIGHT),
      .DATA_WIDTH (DATA_WIDTH)
   ) u_window_gen (
      .clk         (clk),
      .rst         (rst),
      .en          (advance_s),
      .pixel_in    (pixel_in),
      .pixel_valid (pixel_valid),
      .win         (win_s),
      .win_valid   (win_valid_s),
      .win_row     (win_row_s),
      .win_col     (win_col_s)
   );

   // Coefficient RAM; out-of-range addresses are dropped.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NUM_COEF; i++) begin
            coef_r[i] <= '0;
         end
      end else if (wt_we && (int'(wt_addr) < NUM_COEF)) begin
         coef_r[wt_addr] <= wt_data;
      end
   end

   // S1: window register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_win_r   <= '0;
         s1_valid_r <= 1'b0;
         s1_row_r   <= '0;
         s1_col_r   <= '0;
      end else if (advance_s) begin
         s1_win_r   <= win_s;
         s1_valid_r <= win_valid_s;
         s1_row_r   <= win_row_s;
         s1_col_r   <= win_col_s;
      end
   end

   // Products of zero-extended pixels with sign-extended weights.
   always_comb begin
      for (int f = 0; f < NUM_FILTERS; f++) begin
         for (int k = 0; k < NUM_TAPS; k++) begin
            prod_s[f][k] =
               $signed({{(PW-DATA_WIDTH){1'b0}}, s1_win_r[k*DATA_WIDTH +: DATA_WIDTH]}) *
               $signed({{(PW-WEIGHT_WIDTH){coef_r[f*COEF_PER_FILTER+k][WEIGHT_WIDTH-1]}},
                        coef_r[f*COEF_PER_FILTER+k]});
         end
      end
   end

   // S2: product register; bias is captured alongside so a window sees one coefficient set.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int f = 0; f < NUM_FILTERS; f++) begin
            for (int k = 0; k < NUM_TAPS; k++) begin
               prod_r[f][k] <= '0;
            end
            bias_r[f] <= '0;
         end
         s2_valid_r <= 1'b0;
         s2_row_r   <= '0;
         s2_col_r   <= '0;
      end else if (advance_s) begin
         for (int f = 0; f < NUM_FILTERS; f++) begin
            for (int k = 0; k < NUM_TAPS; k++) begin
               prod_r[f][k] <= prod_s[f][k];
            end
            bias_r[f] <= coef_r[f*COEF_PER_FILTER+BIAS_OFFSET];
         end
         s2_valid_r <= s1_valid_r;
         s2_row_r   <= s1_row_r;
         s2_col_r   <= s1_col_r;
      end
   end

   // Adder tree plus bias, then optional ReLU.
   always_comb begin : tree_blk
      logic signed [ACC_WIDTH-1:0] acc_v;
      res_s = '0;
      acc_v = '0;
      for (int f = 0; f < NUM_FILTERS; f++) begin
         acc_v = {{(ACC_WIDTH-WEIGHT_WIDTH){bias_r[f][WEIGHT_WIDTH-1]}}, bias_r[f]};
         for (int k = 0; k < NUM_TAPS; k++) begin
            acc_v = acc_v + {{(ACC_WIDTH-PW){prod_r[f][k][PW-1]}}, prod_r[f][k]};
         end
`ifdef CONV_RELU_EN
         if (acc_v[ACC_WIDTH-1]) begin
            res_s[f*ACC_WIDTH +: ACC_WIDTH] = '0;
         end else begin
            res_s[f*ACC_WIDTH +: ACC_WIDTH] = acc_v;
         end
`else
         res_s[f*ACC_WIDTH +: ACC_WIDTH] = acc_v;
`endif
      end
   end

   // S3: output register, held while downstream stalls.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_data_r  <= '0;
         out_valid_r <= 1'b0;
         out_row_r   <= '0;
         out_col_r   <= '0;
         out_last_r  <= 1'b0;
      end else if (advance_s) begin
         out_data_r  <= res_s;
         out_valid_r <= s2_valid_r;
         out_row_r   <= s2_row_r;
         out_col_r   <= s2_col_r;
         out_last_r  <= s2_valid_r && (s2_row_r == ROW_LAST) && (s2_col_r == COL_LAST);
      end
   end

   assign out_data  = out_data_r;
   assign out_valid = out_valid_r;
   assign out_row   = out_row_r;
   assign out_col   = out_col_r;
   assign out_last  = out_last_r;

endmodule

// File: tb/tb_conv_layer_stream.sv
// Scoreboard bench for conv_layer_stream: a reference convolution computes the
// expected window result on every accepted window-completing pixel.
module tb_conv_layer_stream;

   localparam int W   = 28;
   localparam int H   = 28;
   localparam int NF  = 4;
   localparam int ACC = 20;
   localparam int FRAME = W * H;
   localparam int OUTS  = (W - 2) * (H - 2);
`ifdef CONV_RELU_EN
   localparam logic [ACC-1:0] K_T2 = 20'd0;
   localparam logic [ACC-1:0] K_MIN = 20'd0;
`else
   localparam logic [ACC-1:0] K_T2 = 20'hFE412;
   localparam logic [ACC-1:0] K_MIN = 20'hB8400;
`endif

   typedef struct {
      logic [NF*ACC-1:0] data;
      int                row;
      int                col;
      logic              last;
   } exp_t;

   logic              clk;
   logic              rst;
   logic [7:0]        pixel_in;
   logic              pixel_valid;
   logic              pixel_ready;
   logic              wt_we;
   logic [5:0]        wt_addr;
   logic [7:0]        wt_data;
   logic [NF*ACC-1:0] out_data;
   logic              out_valid;
   logic              out_ready;
   logic [4:0]        out_row;
   logic [4:0]        out_col;
   logic              out_last;

   conv_layer_stream dut (
      .clk(clk), .rst(rst), .pixel_in(pixel_in), .pixel_valid(pixel_valid),
      .pixel_ready(pixel_ready), .wt_we(wt_we), .wt_addr(wt_addr), .wt_data(wt_data),
      .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
      .out_row(out_row), .out_col(out_col), .out_last(out_last)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int   n_checks = 0;
   int   n_errors = 0;
   int   coef [NF][10];
   int   img  [H][W];
   exp_t exp_q [$];
   int   acc_row = 0, acc_col = 0, acc_count = 0;
   int   n_out = 0, n_last = 0;
   int   test_id = 0;
   int   cyc = 0;
   bit   lat_arm = 0, lat_wait = 0;
   int   acc22_cyc = 0;
   bit   stalled_prev = 0;
   logic [NF*ACC-1:0] held_data;

   task automatic chk_eq(input string tag, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   function automatic logic [ACC-1:0] model(input int f, input int r, input int c);
      int s;
      s = coef[f][9];
      for (int i = 0; i < 3; i++)
         for (int j = 0; j < 3; j++)
            s += img[r-2+i][c-2+j] * coef[f][i*3+j];
`ifdef CONV_RELU_EN
      if (s < 0) s = 0;
`endif
      return s[ACC-1:0];
   endfunction

   always @(posedge clk) cyc++;

   // Monitor: pop/compare on output transfers, push expectations on accepts.
   always @(negedge clk) begin
      if (!rst) begin
         if (lat_wait && out_valid) begin
            chk_eq("latency_edges", cyc - acc22_cyc - 1, 3);
            lat_wait = 0;
         end
         if (out_valid && !out_ready) begin
            chk_eq("stall_pixel_ready", pixel_ready, 1'b0);
            if (stalled_prev) chk_eq("stall_hold", out_data, held_data);
            held_data = out_data;
            stalled_prev = 1;
         end else begin
            stalled_prev = 0;
         end
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               chk_eq("spurious_out", exp_q.size(), 1);
            end else begin
               exp_t e;
               e = exp_q.pop_front();
               if (test_id == 2 && n_out == 0) begin
                  chk_eq("t2_f0_const", out_data[0 +: ACC], K_T2);
                  chk_eq("t2_f1_min", out_data[ACC +: ACC], K_MIN);
               end
               chk_eq("data", out_data, e.data);
               chk_eq("row", out_row, e.row);
               chk_eq("col", out_col, e.col);
               chk_eq("last", out_last, e.last);
            end
            n_out++;
            if (out_last) n_last++;
         end
         if (pixel_valid && pixel_ready) begin
            if (acc_row >= 2 && acc_col >= 2) begin
               exp_t e;
               for (int f = 0; f < NF; f++) e.data[f*ACC +: ACC] = model(f, acc_row, acc_col);
               e.row = acc_row - 2;
               e.col = acc_col - 2;
               e.last = (acc_row == H-1) && (acc_col == W-1);
               exp_q.push_back(e);
            end
            if (lat_arm && acc_row == 2 && acc_col == 2) begin
               acc22_cyc = cyc;
               lat_wait = 1;
               lat_arm = 0;
            end
            acc_count++;
            if (acc_col == W-1) begin
               acc_col = 0;
               acc_row = (acc_row == H-1) ? 0 : acc_row + 1;
            end else begin
               acc_col++;
            end
         end
      end
   end

   task automatic load_coefs();
      for (int f = 0; f < NF; f++) begin
         for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            wt_we = 1'b1;
            wt_addr = 6'(f*10 + k);
            wt_data = coef[f][k][7:0];
         end
      end
      @(posedge clk); #1;
      wt_addr = 6'd40;
      wt_data = 8'h55;
      @(posedge clk); #1;
      wt_we = 1'b0;
   endtask

   task automatic stream(input int npix, input bit stall_mode, input bit rand_valid);
      int target;
      int budget;
      target = acc_count + npix;
      budget = 0;
      while (acc_count < target && budget < 20000) begin
         @(posedge clk); #1;
         budget++;
         pixel_valid = rand_valid ? ($urandom_range(0, 1) == 1) : 1'b1;
         pixel_in = img[acc_row][acc_col][7:0];
         out_ready = stall_mode ? (cyc % 3 == 0) : 1'b1;
      end
      pixel_valid = 1'b0;
      chk_eq("stream_accepts", acc_count, target);
   endtask

   task automatic drain();
      int b;
      b = 0;
      pixel_valid = 1'b0;
      out_ready = 1'b1;
      while (exp_q.size() > 0 && b < 200) begin
         @(posedge clk); #1;
         b++;
      end
      repeat (6) @(posedge clk);
      #1;
      chk_eq("drain_empty", exp_q.size(), 0);
   endtask

   task automatic start_test(input int id);
      test_id = id;
      n_out = 0;
      n_last = 0;
   endtask

   initial begin
      rst = 1'b1; pixel_in = 8'd0; pixel_valid = 1'b0; out_ready = 1'b1;
      wt_we = 1'b0; wt_addr = 6'd0; wt_data = 8'd0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      #1;
      chk_eq("rst_out_valid", out_valid, 1'b0);
      chk_eq("rst_out_last", out_last, 1'b0);
      chk_eq("rst_out_data", out_data, 0);
      chk_eq("rst_out_row", out_row, 0);
      chk_eq("rst_out_col", out_col, 0);
      chk_eq("rst_pixel_ready", pixel_ready, 1'b1);

      // T1: all-ones weights and image
      for (int f = 0; f < NF; f++) for (int k = 0; k < 10; k++) coef[f][k] = (k < 9) ? 1 : 0;
      for (int r = 0; r < H; r++) for (int c = 0; c < W; c++) img[r][c] = 1;
      load_coefs();
      start_test(1);
      stream(FRAME, 1'b0, 1'b0);
      drain();
      chk_eq("t1_count", n_out, OUTS);
      chk_eq("t1_lasts", n_last, 1);

      // T2: mixed-sign filter, most negative filter, saturated pixels
      begin
         int f0 [10] = '{9, 11, -2, 1, -2, -11, -17, -9, -8, -10};
         for (int k = 0; k < 10; k++) begin
            coef[0][k] = f0[k];
            coef[1][k] = -128;
            coef[2][k] = (k < 9) ? 1 : 5;
            coef[3][k] = (k == 4) ? 1 : ((k == 9) ? -3 : 0);
         end
      end
      for (int r = 0; r < H; r++) for (int c = 0; c < W; c++) img[r][c] = 255;
      load_coefs();
      start_test(2);
      stream(FRAME, 1'b0, 1'b0);
      drain();
      chk_eq("t2_count", n_out, OUTS);

      // T3: centre-tap pass-through of column index, plus latency
      for (int f = 0; f < NF; f++) for (int k = 0; k < 10; k++) coef[f][k] = (k == 4) ? 1 : 0;
      for (int r = 0; r < H; r++) for (int c = 0; c < W; c++) img[r][c] = c;
      load_coefs();
      start_test(3);
      lat_arm = 1;
      stream(FRAME, 1'b0, 1'b0);
      drain();
      chk_eq("t3_count", n_out, OUTS);
      chk_eq("t3_latency_seen", lat_wait | lat_arm, 1'b0);

      // T4: random data and weights under backpressure and gappy input
      for (int f = 0; f < NF; f++) for (int k = 0; k < 10; k++) coef[f][k] = $urandom_range(0, 255) - 128;
      for (int r = 0; r < H; r++) for (int c = 0; c < W; c++) img[r][c] = $urandom_range(0, 255);
      load_coefs();
      start_test(4);
      stream(FRAME, 1'b1, 1'b1);
      drain();
      chk_eq("t4_count", n_out, OUTS);
      chk_eq("t4_lasts", n_last, 1);

      // T5: reset mid-frame, then two back-to-back frames
      start_test(5);
      stream(300, 1'b0, 1'b0);
      rst = 1'b1;
      exp_q.delete();
      acc_row = 0;
      acc_col = 0;
      stalled_prev = 0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      load_coefs();
      start_test(5);
      stream(2 * FRAME, 1'b0, 1'b0);
      drain();
      chk_eq("t5_count", n_out, 2 * OUTS);
      chk_eq("t5_lasts", n_last, 2);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
